// File: rtl/imm_enc_if.sv
// Request/result bundle for the immediate encoder.
// master = producer/consumer side, slave = encoder side.
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [5:0]  EXTOp;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  iimm_shamt;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm;
  logic [31:0] inst_imm;
  logic        fault;

  modport master (
    output in_valid, imm, EXTOp, out_ready,
    input  in_ready, out_valid, iimm_shamt, iimm, simm, bimm, uimm, jimm,
           inst_imm, fault
  );

  modport slave (
    input  in_valid, imm, EXTOp, out_ready,
    output in_ready, out_valid, iimm_shamt, iimm, simm, bimm, uimm, jimm,
           inst_imm, fault
  );
endinterface

// File: rtl/imm_enc.sv
// Immediate encoder: packs a 32-bit immediate into the selected RISC-V format
// behind a one-deep valid/ready register, flagging and counting unrepresentable values.
module imm_enc #(
  parameter int unsigned FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  imm_enc_if.slave          bus,
  output logic [FCNT_W-1:0] fault_cnt
);

  typedef enum logic [5:0] {
    OP_ISHAMT = 6'd0,
    OP_I      = 6'd1,
    OP_S      = 6'd2,
    OP_B      = 6'd3,
    OP_U      = 6'd4,
    OP_J      = 6'd5
  } ext_op_e;

  typedef struct packed {
    logic [4:0]  shamt;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [31:0] inst;
    logic        fault;
  } res_t;

  res_t              enc;
  res_t              res_d, res_q;
  logic              out_valid_d, out_valid_q;
  logic [FCNT_W-1:0] fault_cnt_d, fault_cnt_q;
  logic              accept, consume;
  logic [31:0]       imm;

  // Fields are truncated regardless of fault; the flag alone reports range loss.
  always_comb begin
    enc = '0;
    imm = bus.imm;
    case (bus.EXTOp)
      OP_ISHAMT: begin
        enc.shamt = imm[4:0];
        enc.inst  = {7'b0, imm[4:0], 20'b0};
        enc.fault = |imm[31:5];
      end
      OP_I: begin
        enc.iimm  = imm[11:0];
        enc.inst  = {imm[11:0], 20'b0};
        enc.fault = imm[31:12] != {20{imm[11]}};
      end
      OP_S: begin
        enc.simm  = imm[11:0];
        enc.inst  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        enc.fault = imm[31:12] != {20{imm[11]}};
      end
      OP_B: begin
        enc.bimm  = imm[12:1];
        enc.inst  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        enc.fault = imm[0] || (imm[31:13] != {19{imm[12]}});
      end
      OP_U: begin
        enc.uimm  = imm[31:12];
        enc.inst  = {imm[31:12], 12'b0};
        enc.fault = |imm[11:0];
      end
      OP_J: begin
        enc.jimm  = imm[20:1];
        enc.inst  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        enc.fault = imm[0] || (imm[31:21] != {11{imm[20]}});
      end
      default: enc.fault = 1'b1;
    endcase
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    fault_cnt_d = fault_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d       = enc;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    if (consume && res_q.fault && (fault_cnt_q != '1))
      fault_cnt_d = fault_cnt_q + FCNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      fault_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.iimm_shamt = res_q.shamt;
  assign bus.iimm       = res_q.iimm;
  assign bus.simm       = res_q.simm;
  assign bus.bimm       = res_q.bimm;
  assign bus.uimm       = res_q.uimm;
  assign bus.jimm       = res_q.jimm;
  assign bus.inst_imm   = res_q.inst;
  assign bus.fault      = res_q.fault;
  assign fault_cnt      = fault_cnt_q;

endmodule
